// File: rtl/video_pkg.sv
// Shared types, bar colours and helper functions for the video test-pattern source.
package video_pkg;

    typedef logic [23:0] rgb_t;

    typedef struct packed {
        logic [11:0] active;
        logic [11:0] fp;
        logic [11:0] sync;
        logic [11:0] bp;
    } timing_t;

    localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
    localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
    localparam rgb_t BAR_CYAN    = 24'h00FFFF;
    localparam rgb_t BAR_GREEN   = 24'h00FF00;
    localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
    localparam rgb_t BAR_RED     = 24'hFF0000;
    localparam rgb_t BAR_BLUE    = 24'h0000FF;
    localparam rgb_t BAR_BLACK   = 24'h000000;

    // 13 bits so a full 4096-count axis still fits.
    function automatic logic [12:0] total(input timing_t t);
        return 13'(t.active) + 13'(t.fp) + 13'(t.sync) + 13'(t.bp);
    endfunction

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// One raster axis: wrapping position counter with blank/sync decode and a wrap
// strobe for chaining the next axis.
module video_timing_cnt
    import video_pkg::*;
#(
    parameter timing_t TIM = '{active: 12'd1280, fp: 12'd110, sync: 12'd40, bp: 12'd220},
    parameter logic    POL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        adv_i,
    output logic [11:0] cnt_o,
    output logic        wrap_o,
    output logic        blank_o,
    output logic        sync_o
);

    localparam logic [12:0] LAST     = total(TIM) - 13'd1;
    localparam logic [12:0] ACT_END  = 13'(TIM.active);
    localparam logic [12:0] SYNC_BEG = 13'(TIM.active) + 13'(TIM.fp);
    localparam logic [12:0] SYNC_END = SYNC_BEG + 13'(TIM.sync);

    logic [12:0] cnt_x;
    logic        in_sync;

    assign cnt_x   = {1'b0, cnt_o};
    assign wrap_o  = adv_i && (cnt_x == LAST);
    assign blank_o = (cnt_x >= ACT_END);
    assign in_sync = (cnt_x >= SYNC_BEG) && (cnt_x < SYNC_END);
    assign sync_o  = in_sync ? POL : ~POL;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (adv_i) begin
            cnt_o <= wrap_o ? 12'd0 : cnt_o + 12'd1;
        end
    end

endmodule

// File: rtl/video_tpg_timing.sv
// Raster timing and colour-bar / greyscale-ramp test-pattern source.
// Optional white 1-pixel border when VIDEO_TPG_BORDER_EN is defined.
module video_tpg_timing
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cen_i,
    input  logic        pat_sel_i,
    output logic [23:0] vid_rgb_o,
    output logic [1:0]  vh_blank_o,
    output logic [2:0]  dvh_sync_o,
    output logic        frame_start_o
);

    localparam timing_t H_TIM = '{active: 12'(H_ACTIVE), fp: 12'(H_FP),
                                  sync: 12'(H_SYNC), bp: 12'(H_BP)};
    localparam timing_t V_TIM = '{active: 12'(V_ACTIVE), fp: 12'(V_FP),
                                  sync: 12'(V_SYNC), bp: 12'(V_BP)};
    localparam logic [11:0] BW_LAST = 12'(H_ACTIVE / 8 - 1);

    logic [11:0] h_cnt, v_cnt;
    logic        h_wrap, v_wrap, h_blank, v_blank, h_sync, v_sync;
    logic [11:0] bar_cnt;
    logic [2:0]  bar_idx;
    logic        at_origin;
    logic        pat_q;
    logic        pat_eff;
    logic        de;
    rgb_t        pix;

    video_timing_cnt #(.TIM(H_TIM), .POL(HS_POL)) u_h_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .adv_i   (cen_i),
        .cnt_o   (h_cnt),
        .wrap_o  (h_wrap),
        .blank_o (h_blank),
        .sync_o  (h_sync)
    );

    video_timing_cnt #(.TIM(V_TIM), .POL(VS_POL)) u_v_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .adv_i   (cen_i & h_wrap),
        .cnt_o   (v_cnt),
        .wrap_o  (v_wrap),
        .blank_o (v_blank),
        .sync_o  (v_sync)
    );

    // at_origin tracks counters sitting at (0,0); the frame-start pixel uses
    // the live select so the new pattern covers the whole frame.
    assign pat_eff = at_origin ? pat_sel_i : pat_q;
    assign de      = ~h_blank & ~v_blank;

    always_comb begin
        pix = pat_eff ? {3{h_cnt[7:0]}} : bar_colour(bar_idx);
`ifdef VIDEO_TPG_BORDER_EN
        if ((h_cnt == 12'd0) || (h_cnt == 12'(H_ACTIVE - 1)) ||
            (v_cnt == 12'd0) || (v_cnt == 12'(V_ACTIVE - 1))) begin
            pix = BAR_WHITE;
        end
`endif
    end

    // Bar position sub-counter replaces a divide of h_cnt by the bar width.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bar_cnt   <= '0;
            bar_idx   <= '0;
            at_origin <= 1'b1;
            pat_q     <= 1'b0;
        end else if (cen_i) begin
            at_origin <= v_wrap;
            if (at_origin) begin
                pat_q <= pat_sel_i;
            end
            if (h_wrap) begin
                bar_cnt <= '0;
                bar_idx <= '0;
            end else if (bar_cnt == BW_LAST) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_cnt <= bar_cnt + 12'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vid_rgb_o     <= '0;
            vh_blank_o    <= 2'b11;
            dvh_sync_o    <= {1'b0, ~VS_POL, ~HS_POL};
            frame_start_o <= 1'b0;
        end else if (cen_i) begin
            vid_rgb_o     <= de ? pix : 24'h000000;
            vh_blank_o    <= {v_blank, h_blank};
            dvh_sync_o    <= {de, v_sync, h_sync};
            frame_start_o <= at_origin;
        end
    end

endmodule

// File: tb/tb_video_tpg_timing.sv
// Directed, table-driven bench for video_tpg_timing on a 24x7 raster.
module tb_video_tpg_timing;

    logic        clk;
    logic        rst;
    logic        cen;
    logic        pat_sel;
    logic [23:0] vid_rgb;
    logic [1:0]  vh_blank;
    logic [2:0]  dvh_sync;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int pix_n  = -1;

    typedef struct {
        int          pix;
        logic [23:0] rgb;
        logic [1:0]  blank;
        logic [2:0]  sync;
        logic        fs;
    } vec_t;

    vec_t vecs[$];

    video_tpg_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cen_i         (cen),
        .pat_sel_i     (pat_sel),
        .vid_rgb_o     (vid_rgb),
        .vh_blank_o    (vh_blank),
        .dvh_sync_o    (dvh_sync),
        .frame_start_o (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic c, input logic p);
        rst     = r;
        cen     = c;
        pat_sel = p;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkPix(input string name, input logic [23:0] rgb, input logic [1:0] blank,
                            input logic [2:0] sync, input logic fs);
        checkOutput({name, "_rgb"}, 32'(vid_rgb), 32'(rgb));
        checkOutput({name, "_blank"}, 32'(vh_blank), 32'(blank));
        checkOutput({name, "_sync"}, 32'(dvh_sync), 32'(sync));
        checkOutput({name, "_fs"}, 32'(frame_start), 32'(fs));
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic stepPix();
        stepCycle();
        pix_n++;
    endtask

    task automatic runTo(input int target);
        for (int k = 0; k < 1000 && pix_n < target; k++) stepPix();
        checkOutput("run_to", 32'(pix_n), 32'(target));
    endtask

    task automatic doReset(input logic p);
        applyStimulus(1'b1, 1'b1, p);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        pix_n = -1;
    endtask

    function automatic void addVec(input int x, input int y, input logic [23:0] rgb,
                                   input logic [1:0] blank, input logic [2:0] sync, input logic fs);
        vec_t v;
        v.pix = y * 24 + x; v.rgb = rgb; v.blank = blank; v.sync = sync; v.fs = fs;
        vecs.push_back(v);
    endfunction

    initial begin
        int idx;
        int fs_first, fs_second;
        int rise1, rise2, hold_err;
        logic [31:0] prev;
        logic cen_prev;

        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkPix("reset", 24'h000000, 2'b11, 3'b000, 1'b0);

        // Expected outputs for frame 0 (bars) and the first pixel of frame 1.
        addVec(0, 0, 24'hFFFFFF, 2'b00, 3'b100, 1'b1);
        addVec(1, 0, 24'hFFFFFF, 2'b00, 3'b100, 1'b0);
        addVec(2, 0, 24'hFFFF00, 2'b00, 3'b100, 1'b0);
        addVec(3, 0, 24'hFFFF00, 2'b00, 3'b100, 1'b0);
        addVec(4, 0, 24'h00FFFF, 2'b00, 3'b100, 1'b0);
        addVec(6, 0, 24'h00FF00, 2'b00, 3'b100, 1'b0);
        addVec(8, 0, 24'hFF00FF, 2'b00, 3'b100, 1'b0);
        addVec(10, 0, 24'hFF0000, 2'b00, 3'b100, 1'b0);
        addVec(12, 0, 24'h0000FF, 2'b00, 3'b100, 1'b0);
        addVec(14, 0, 24'h000000, 2'b00, 3'b100, 1'b0);
        addVec(15, 0, 24'h000000, 2'b00, 3'b100, 1'b0);
        addVec(16, 0, 24'h000000, 2'b01, 3'b000, 1'b0);
        addVec(17, 0, 24'h000000, 2'b01, 3'b000, 1'b0);
        addVec(18, 0, 24'h000000, 2'b01, 3'b001, 1'b0);
        addVec(19, 0, 24'h000000, 2'b01, 3'b001, 1'b0);
        addVec(20, 0, 24'h000000, 2'b01, 3'b000, 1'b0);
        addVec(23, 0, 24'h000000, 2'b01, 3'b000, 1'b0);
        addVec(0, 1, 24'hFFFFFF, 2'b00, 3'b100, 1'b0);
        addVec(3, 3, 24'hFFFF00, 2'b00, 3'b100, 1'b0);
        addVec(15, 3, 24'h000000, 2'b00, 3'b100, 1'b0);
        addVec(0, 4, 24'h000000, 2'b10, 3'b000, 1'b0);
        addVec(18, 4, 24'h000000, 2'b11, 3'b001, 1'b0);
        addVec(0, 5, 24'h000000, 2'b10, 3'b010, 1'b0);
        addVec(19, 5, 24'h000000, 2'b11, 3'b011, 1'b0);
        addVec(23, 5, 24'h000000, 2'b11, 3'b010, 1'b0);
        addVec(0, 6, 24'h000000, 2'b10, 3'b000, 1'b0);
        addVec(23, 6, 24'h000000, 2'b11, 3'b000, 1'b0);
        addVec(0, 7, 24'hFFFFFF, 2'b00, 3'b100, 1'b1);
        addVec(1, 7, 24'hFFFFFF, 2'b00, 3'b100, 1'b0);

        @(negedge clk);
        rst   = 1'b0;
        pix_n = -1;
        idx   = 0;
        for (int n = 0; n <= 170; n++) begin
            stepPix();
            while (idx < vecs.size() && vecs[idx].pix == pix_n) begin
                checkPix($sformatf("vec%0d", idx), vecs[idx].rgb, vecs[idx].blank,
                         vecs[idx].sync, vecs[idx].fs);
                idx++;
            end
        end
        checkOutput("vec_count", 32'(idx), 32'(vecs.size()));

        // Frame-start period with cen held high.
        fs_first  = -1;
        fs_second = -1;
        for (int c = 0; c < 400 && fs_second < 0; c++) begin
            stepCycle();
            if (frame_start) begin
                if (fs_first < 0) fs_first = c;
                else fs_second = c;
            end
        end
        checkOutput("fs_seen", 32'(fs_second >= 0), 32'd1);
        checkOutput("fs_period", 32'(fs_second - fs_first), 32'd168);

        // One enable every three clocks: outputs hold, line period stretches.
        rise1    = -1;
        rise2    = -1;
        hold_err = 0;
        prev     = {vid_rgb, 1'b0, vh_blank, dvh_sync, frame_start};
        for (int c = 0; c < 300; c++) begin
            cen_prev = (c % 3 == 0);
            applyStimulus(1'b0, cen_prev, 1'b0);
            stepCycle();
            if (!cen_prev && ({vid_rgb, 1'b0, vh_blank, dvh_sync, frame_start} !== prev))
                hold_err++;
            if (vh_blank[0] && !prev[4]) begin
                if (rise1 < 0) rise1 = c;
                else if (rise2 < 0) rise2 = c;
            end
            prev = {vid_rgb, 1'b0, vh_blank, dvh_sync, frame_start};
        end
        checkOutput("cen_hold", 32'(hold_err), 32'd0);
        checkOutput("cen_line_period", 32'(rise2 - rise1), 32'd72);

        // Pattern select raised mid-frame takes effect at the next frame.
        doReset(1'b0);
        runTo(29);
        pat_sel = 1'b1;
        runTo(50);
        checkOutput("pat_mid_frame", 32'(vid_rgb), 32'h00FFFF00);
        runTo(168);
        checkOutput("ramp_x0", 32'(vid_rgb), 32'h00000000);
        checkOutput("ramp_fs", 32'(frame_start), 32'd1);
        runTo(173);
        checkOutput("ramp_x5", 32'(vid_rgb), 32'h00050505);
        runTo(183);
        checkOutput("ramp_x15", 32'(vid_rgb), 32'h000F0F0F);

        // Asynchronous reset at pixel (9,2), then restart from (0,0).
        doReset(1'b0);
        runTo(57);
        checkOutput("pre_areset_rgb", 32'(vid_rgb), 32'h00FF00FF);
        #2;
        rst = 1'b1;
        #1;
        checkPix("areset", 24'h000000, 2'b11, 3'b000, 1'b0);
        #2;
        rst   = 1'b0;
        pix_n = -1;
        stepPix();
        checkPix("restart0", 24'hFFFFFF, 2'b00, 3'b100, 1'b1);
        stepPix();
        checkPix("restart1", 24'hFFFFFF, 2'b00, 3'b100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_tpg_timing.md
Name: video_tpg_timing

Overview:
- Upstream source stage for the video pixel-processing chain.
- Generates raster timing: blanking, H/V sync and data-enable.
- Generates a test-pattern (8 colour bars or greyscale ramp) on the 24-bit RGB bus that feeds the pixel-processing stage directly.
- All state advances only on the video clock enable.

Parameters:
- H_ACTIVE, 1280, active pixels per line; must be a multiple of 8.
- H_FP, 110, horizontal front porch in pixels.
- H_SYNC, 40, horizontal sync width in pixels.
- H_BP, 220, horizontal back porch in pixels.
- V_ACTIVE, 720, active lines per frame.
- V_FP, 5, vertical front porch in lines.
- V_SYNC, 5, vertical sync width in lines.
- V_BP, 20, vertical back porch in lines.
- HS_POL, 1, active level of Hsync.
- VS_POL, 1, active level of Vsync.

Ports:
- clk_i  in  1  video clock.
- rst_i  in  1  reset; asynchronous, active-high.
- cen_i  in  1  pixel clock enable.
- pat_sel_i  in  1  pattern select: 0 = colour bars, 1 = greyscale ramp.
- vid_rgb_o  out  24  pixel colour: R[23:16], G[15:8], B[7:0].
- vh_blank_o  out  2  {Vblank, Hblank}; active-high.
- dvh_sync_o  out  3  {D_sync, Vsync, Hsync}. D_sync is data-enable, high in active video.
- frame_start_o  out  1  high while the output pixel is (x=0, y=0).

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL likewise. Both must be ≤ 4096. h_cnt and v_cnt are 12-bit.
- Only on cycles with cen_i=1:
  - h_cnt increments, wrapping from H_TOTAL-1 to 0.
  - On that wrap, v_cnt increments, wrapping from V_TOTAL-1 to 0.
- With cen_i=0, all registers and outputs hold.
- Regions:
  - Hblank = (h_cnt ≥ H_ACTIVE).
  - Hsync active when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - Vblank and Vsync are defined the same way on v_cnt. Vsync changes on the h_cnt wrap cycle, aligned with the line start.
  - D_sync = ~Hblank & ~Vblank.
- Latency: all outputs are registered and reflect the counter state one enabled cycle earlier. Every output is aligned to the same pixel.
- Colour bars:
  - Bar width BW = H_ACTIVE/8.
  - Bar index comes from a bar sub-counter; no divider. The sub-counter resets at h_cnt=0.
  - Order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Ramp: R=G=B = h_cnt[7:0], restarting every 256 pixels.
- RGB is 000000 whenever D_sync=0.
- pat_sel_i is sampled only at the frame start (h_cnt=0, v_cnt=0, cen_i=1). A mid-frame change takes effect on the next frame.
- Reset values (asynchronous, immediate):
  - Counters 0; vid_rgb_o 0; vh_blank_o 2'b11; frame_start_o 0.
  - dvh_sync_o = {1'b0, ~VS_POL, ~HS_POL}.
  - Latched pattern select = 0.
- After reset release, the first enabled cycle loads outputs for pixel (0,0).
- Reset asserted mid-frame abandons the frame; there is no partial-line completion.

Optional Feature:
- Macro: VIDEO_TPG_BORDER_EN.
- Defined: a 1-pixel white (FFFFFF) border overrides the pattern where x ∈ {0, H_ACTIVE-1} or y ∈ {0, V_ACTIVE-1}, within active video only.
- Undefined: no border logic; the pattern is unmodified.

Decomposition:
- Shared package video_pkg holds:
  - typedef rgb_t (24-bit);
  - typedef timing_t (struct: active, fp, sync, bp);
  - constants for the 8 bar colours;
  - function total(timing_t).
- Sub-module video_timing_cnt, instantiated once per axis, holds:
  - counter, wrap and blank/sync decode;
  - an advance input (cen for H, cen & h_wrap for V);
  - wrap output for chaining.

Test Plan (bench parameters: H 16/2/2/4 → H_TOTAL 24; V 4/1/1/1 → V_TOTAL 7; cen_i=1):
- Reset, then release: outputs read reset values.
  - First output, one cycle after the first enabled cycle: pixel (0,0), rgb FFFFFF, D_sync=1, frame_start_o=1.
- Line timing:
  - Hblank high for output pixels 16..23.
  - Hsync (HS_POL=1) high exactly at pixels 18,19.
  - Period 24 cycles.
- Frame timing:
  - Vblank at lines 4..6; Vsync only at line 5.
  - frame_start_o pulses every 168 cycles.
- Bars, pat_sel_i=0, BW=2:
  - Line 0 RGB sequence FFFFFF×2, FFFF00×2, 00FFFF×2, 00FF00×2, FF00FF×2, FF0000×2, 0000FF×2, 000000×2.
  - Blanking RGB is 0.
- cen_i toggled 1-of-3 cycles: period 72 clocks/line; outputs hold between enables.
- pat_sel_i raised mid-frame:
  - Remainder of the frame stays bars.
  - Next frame is a ramp: pixel x=5 → 050505.
- Async reset at pixel (9,2): outputs go to reset values before the next clock edge; restart at (0,0).
